// File: rtl/fc_argmax_seq.sv
// fc_argmax_seq
//   Fully-connected classifier stage with sequential argmax. One IN_LENGTH
//   element signed feature vector is multiplied against an OUT_POINT x
//   IN_LENGTH signed weight memory. Each dot product is shifted right by
//   FRAC_SHIFT and saturated to DATA_W. The class with the highest score is
//   then selected, and ties resolve to the lowest class index.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   in_data      packed input vector, element i at [i*DATA_W +: DATA_W]
//   in_valid     input vector valid
//   in_ready     high while idle (and not in reset)
//   w_wr_en      weight write strobe, honoured only while idle
//   w_wr_addr    weight address, o*IN_LENGTH + i
//   w_wr_data    weight value
//   busy         frame in progress
//   out_valid    one-cycle result pulse
//   out_scores   score o at [o*DATA_W +: DATA_W]
//   out_onehot   winning class, one-hot
//   out_index    winning class number
module fc_argmax_seq #(
  parameter int    DATA_W      = 16,
  parameter int    W_W         = 16,
  parameter int    IN_LENGTH   = 32,
  parameter int    OUT_POINT   = 4,
  parameter int    FRAC_SHIFT  = 12,
  parameter int    WEIGHTS_NUM = OUT_POINT * IN_LENGTH,
  parameter int    W_ADDR_W    = $clog2(WEIGHTS_NUM),
  parameter int    IDX_W       = (OUT_POINT > 1) ? $clog2(OUT_POINT) : 1,
  parameter int    ACC_W       = DATA_W + W_W + $clog2(IN_LENGTH),
  parameter string INIT_FILE   = "fc_weights.txt"
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W*IN_LENGTH-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          w_wr_en,
  input  logic [W_ADDR_W-1:0]           w_wr_addr,
  input  logic [W_W-1:0]                w_wr_data,
  output logic                          busy,
  output logic                          out_valid,
  output logic [DATA_W*OUT_POINT-1:0]   out_scores,
  output logic [OUT_POINT-1:0]          out_onehot,
  output logic [IDX_W-1:0]              out_index
);

  localparam int E_W  = (IN_LENGTH > 1) ? $clog2(IN_LENGTH) : 1;
  localparam int PW   = DATA_W + W_W;

  localparam logic [W_ADDR_W-1:0] LAST_ADDR = W_ADDR_W'(WEIGHTS_NUM - 1);
  localparam logic [E_W-1:0]      LAST_ELEM = E_W'(IN_LENGTH - 1);
  localparam logic [IDX_W-1:0]    LAST_CLS  = IDX_W'(OUT_POINT - 1);

  localparam logic signed [ACC_W-1:0]  SMAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0]  SMIN = -SMAX - ACC_W'(1);
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAC    = 3'd1,
    DRAIN  = 3'd2,
    SCALE  = 3'd3,
    ARGMAX = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state;

  // weight memory, synchronous read
  logic signed [W_W-1:0] wmem [WEIGHTS_NUM];
  logic signed [W_W-1:0] w_q;

  // latched input vector
  logic signed [DATA_W-1:0] vec [IN_LENGTH];

  // address generation: element and channel counters track addr without a divider
  logic [W_ADDR_W-1:0] addr;
  logic [E_W-1:0]      elem;
  logic [IDX_W-1:0]    ch;

  // MAC pipeline
  logic                     s1_valid;
  logic [IDX_W-1:0]         s1_ch;
  logic signed [DATA_W-1:0] x_q;
  logic                     s2_valid;
  logic [IDX_W-1:0]         s2_ch;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc [OUT_POINT];

  logic [1:0]               drain_cnt;
  logic signed [DATA_W-1:0] score [OUT_POINT];
  logic [IDX_W-1:0]         arg_k;
  logic signed [DATA_W-1:0] best;
  logic [IDX_W-1:0]         best_idx;

  logic accept;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && (state == IDLE);

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_SHIFT;
    if (s > SMAX)      return DMAX;
    else if (s < SMIN) return DMIN;
    else               return s[DATA_W-1:0];
  endfunction

  // Memory is intentionally not reset; writes only land while idle, so they
  // never collide with MAC reads. A write coincident with an accept lands
  // before the first read.
  always_ff @(posedge clk) begin
    if (w_wr_en && state == IDLE)
      wmem[w_wr_addr] <= w_wr_data;
    w_q <= wmem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      elem       <= '0;
      ch         <= '0;
      s1_valid   <= 1'b0;
      s1_ch      <= '0;
      x_q        <= '0;
      s2_valid   <= 1'b0;
      s2_ch      <= '0;
      prod       <= '0;
      drain_cnt  <= '0;
      arg_k      <= '0;
      best       <= '0;
      best_idx   <= '0;
      out_valid  <= 1'b0;
      out_scores <= '0;
      out_onehot <= '0;
      out_index  <= '0;
      for (int unsigned i = 0; i < IN_LENGTH; i++) vec[i] <= '0;
      for (int unsigned o = 0; o < OUT_POINT; o++) begin
        acc[o]   <= '0;
        score[o] <= '0;
      end
    end else begin
      out_valid <= 1'b0;

      // pipeline: t issue addr, t+1 weight/element, t+2 product, t+3 accumulate
      s1_valid <= (state == MAC);
      s1_ch    <= ch;
      x_q      <= vec[elem];
      s2_valid <= s1_valid;
      s2_ch    <= s1_ch;
      prod     <= PW'(w_q) * PW'(x_q);

      if (accept) begin
        for (int unsigned o = 0; o < OUT_POINT; o++) acc[o] <= '0;
      end else if (s2_valid) begin
        acc[s2_ch] <= acc[s2_ch] + ACC_W'(prod);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < IN_LENGTH; i++)
              vec[i] <= in_data[i*DATA_W +: DATA_W];
            addr  <= '0;
            elem  <= '0;
            ch    <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          addr <= addr + W_ADDR_W'(1);
          if (elem == LAST_ELEM) begin
            elem <= '0;
            ch   <= ch + IDX_W'(1);
          end else begin
            elem <= elem + E_W'(1);
          end
          if (addr == LAST_ADDR) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) state <= SCALE;
        end
        SCALE: begin
          for (int unsigned o = 0; o < OUT_POINT; o++) score[o] <= sat(acc[o]);
          arg_k <= '0;
          state <= ARGMAX;
        end
        ARGMAX: begin
          // strict greater-than keeps the earliest index on ties
          if (arg_k == '0 || score[arg_k] > best) begin
            best     <= score[arg_k];
            best_idx <= arg_k;
          end
          arg_k <= arg_k + IDX_W'(1);
          if (arg_k == LAST_CLS) state <= DONE;
        end
        DONE: begin
          for (int unsigned o = 0; o < OUT_POINT; o++)
            out_scores[o*DATA_W +: DATA_W] <= score[o];
          out_onehot <= OUT_POINT'(1) << best_idx;
          out_index  <= best_idx;
          out_valid  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
